nv_pulse_serializer: RTL and testbench
======================================

Name: nv_pulse_serializer

Overview:
- Parallel-to-serial transmitter that emits an NV control pulse sequence on a single output, MSB first.
- Each bit is held for a programmable number of clock cycles via an internal clock-enable divider. No generated clock is used.
- Sits between the sequence controller FSM (which loads a word and monitors completion) and the laser/MW drive pin.

Parameters:
- DATA_W, 8, width of the parallel word (>=2).
- CLK_DIV, 4, clock cycles per serial bit (>=1). CLK_DIV=1 means one bit per clock.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level request. Sampled only in IDLE and DONE.
- data_in  input  DATA_W  word to transmit. Captured on the accepting edge.
- serial_data_out  output  1  serial bit stream. Registered.
- done_transmit  output  1  high once the full word has been sent. Sticky.
- busy  output  1  high while shifting.

Behaviour:
- Reset: asynchronous, active-high.
  - serial_data_out=0, done_transmit=0, busy=0.
  - State=IDLE. Divider count=0, bit count=0, shift register=0.
- All outputs are registered. There are no combinational input-to-output paths.
- IDLE state:
  - serial_data_out=0.
  - On a rising edge with start=1 (and reset=0): load data_in into the shift register, drive serial_data_out=data_in[DATA_W-1], set busy=1, clear divider and bit count, go to SHIFT.
  - Latency: the first bit appears 1 cycle after start is sampled.
- SHIFT state:
  - The divider counts 0..CLK_DIV-1. Each bit is held exactly CLK_DIV cycles.
  - When the divider reaches CLK_DIV-1 and more bits remain: shift left, present the next bit, increment the bit count, reset the divider.
  - Data order: MSB first, bits DATA_W-1 down to 0.
  - start and data_in are ignored while shifting.
- End of last bit: on the edge that ends the final bit period:
  - serial_data_out=0, busy=0, done_transmit=1, go to DONE.
  - done_transmit rises exactly DATA_W*CLK_DIV cycles after the first bit appears.
- DONE state:
  - done_transmit held 1 and serial_data_out=0.
  - If start=0 on an edge: clear done_transmit and go to IDLE.
  - If start remains 1: stay in DONE. A continuously high start does not retransmit; a new word requires start low for at least one cycle, or reset.
- Restart/abort: the controller restarts by pulsing reset with start held high. After reset deasserts, the next edge with start=1 begins a fresh transmission of the current data_in.
- Reset mid-transmission: aborts immediately and asynchronously. Output goes to 0 with no partial-done indication.
- busy and done_transmit are never high simultaneously.
- Counter widths: the divider is wide enough for CLK_DIV-1 and the bit counter for DATA_W. No wrap-around occurs within a word.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After bit 0, one extra bit period (CLK_DIV cycles) carries even parity, the XOR of the captured word.
  - done_transmit rises (DATA_W+1)*CLK_DIV cycles after the first bit.
  - Parity is computed from the word captured at start, not live data_in.
- When undefined: no parity bit and no parity logic. Timing is as described in Behaviour.

Test Plan:
- Basic shift: DATA_W=8, CLK_DIV=4, data_in=8'hD7, reset released, start=1.
  - Response: serial_data_out 1,1,0,1,0,1,1,1, each bit 4 cycles, first bit 1 cycle after start.
  - done_transmit=1 exactly 32 cycles after the first bit; busy=1 during those 32 cycles.
- Sticky done / re-arm: hold start=1 after the 8'hD7 transfer completes.
  - Response: done stays 1 and output stays 0 for more than 50 cycles.
  - Then drop start for 1 cycle and raise it with data_in=8'h29: done clears, and 0,0,1,0,1,0,0,1 is sent.
- Abort: assert reset asynchronously mid-word (after 3 bits of 8'hA6).
  - Response: outputs go to 0 immediately without waiting for a clock edge; done never asserts.
  - After reset is released with start=1, all 8 bits of 8'hA6 are sent from the start.
- Input stability: change data_in every cycle during SHIFT.
  - Response: the transmitted stream equals the captured word only.
- CLK_DIV=1 corner: data_in=8'h01.
  - Response: 7 cycles low then 1 cycle high; done asserts on the 9th edge after start is sampled.
- Parity (SER_PARITY_EN defined): data_in=8'hD7, which has 6 ones.
  - Response: parity bit 0 appended for 4 cycles; done at 36 cycles.
  - With data_in=8'hD6: parity bit 1.

Source files
------------

// File: rtl/nv_pulse_serializer_if.sv
// rtl/nv_pulse_serializer_if.sv - handshake/data bundle between sequence controller and pulse serializer
interface nv_pulse_serializer_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              serial_data_out;
    logic              done_transmit;
    logic              busy;

    // Sequence controller side: requests a transfer and watches completion
    modport master (
        output start,
        output data_in,
        input  serial_data_out,
        input  done_transmit,
        input  busy
    );

    // Serializer side
    modport slave (
        input  start,
        input  data_in,
        output serial_data_out,
        output done_transmit,
        output busy
    );
endinterface

// File: rtl/nv_pulse_serializer.sv
// rtl/nv_pulse_serializer.sv - MSB-first pulse serializer with clock-enable bit divider; optional SER_PARITY_EN appends an even-parity bit
module nv_pulse_serializer #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    nv_pulse_serializer_if.slave bus
);
    // Divider must hold CLK_DIV-1; keep at least one bit so CLK_DIV=1 still elaborates.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Bit counter must hold DATA_W (the parity slot index when parity is enabled).
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              ser_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] shift_next;
    logic              next_bit;
    logic              last_period;

`ifdef SER_PARITY_EN
    logic              parity_q;
    logic              parity_slot;
`endif

    // Next shift-register value and the bit presented in the following bit period
    always_comb begin
        shift_next = shift_reg << 1;
`ifdef SER_PARITY_EN
        // Bit 0 is ending: the following period carries the parity of the captured word.
        parity_slot = (bit_cnt == BIT_LAST);
        last_period = (bit_cnt == BIT_W'(DATA_W));
        next_bit    = parity_slot ? parity_q : shift_next[DATA_W-1];
`else
        last_period = (bit_cnt == BIT_LAST);
        next_bit    = shift_next[DATA_W-1];
`endif
    end

    // Control FSM with registered outputs; reset aborts immediately with no done indication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ser_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ser_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Capture the word; data_in is ignored from here until the next accept.
                        shift_reg <= bus.data_in;
                        ser_q     <= bus.data_in[DATA_W-1];
                        busy_q    <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
`ifdef SER_PARITY_EN
                        parity_q  <= ^bus.data_in;
`endif
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (last_period) begin
                            ser_q  <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            shift_reg <= shift_next;
                            ser_q     <= next_bit;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // done is sticky while start stays high; a low start re-arms the block.
                    ser_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (!bus.start) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    ser_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.serial_data_out = ser_q;
    assign bus.busy            = busy_q;
    assign bus.done_transmit   = done_q;

endmodule

// File: tb/tb_nv_pulse_serializer.sv
// tb/tb_nv_pulse_serializer.sv - self-checking bench for nv_pulse_serializer
module tb_nv_pulse_serializer;
    localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef bit bitq_t[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_bits;
        logic       exp_par;
        bit         scramble;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    nv_pulse_serializer_if #(.DATA_W(DATA_W)) bus4 ();
    nv_pulse_serializer_if #(.DATA_W(DATA_W)) bus1 ();

    nv_pulse_serializer #(.DATA_W(DATA_W), .CLK_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    nv_pulse_serializer #(.DATA_W(DATA_W), .CLK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        else
            passed++;
    endtask

    // Expected per-cycle line level: each listed bit MSB first held div cycles, then optional parity.
    function automatic bitq_t expand(input logic [7:0] bits, input logic par, input int div);
        bitq_t q;
        for (int i = 7; i >= 0; i--)
            for (int c = 0; c < div; c++)
                q.push_back(bits[i]);
        if (PAR == 1)
            for (int c = 0; c < div; c++)
                q.push_back(par);
        return q;
    endfunction

    // Reference model: word sent MSB first, parity = odd number of ones in the word.
    function automatic bitq_t model_stream(input logic [7:0] w, input int div);
        return expand(w, ($countones(w) % 2) == 1, div);
    endfunction

    // Called at a negedge with start/data_in already set; checks the whole transfer on dut4.
    task automatic check_stream(input bitq_t q, input string name, input bit scramble);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            check($sformatf("%s bit%0d", name, k),
                  {bus4.busy, bus4.done_transmit, bus4.serial_data_out},
                  {1'b1, 1'b0, q[k]});
            if (scramble) bus4.data_in = 8'($urandom);
            @(negedge clk);
        end
        check($sformatf("%s done", name),
              {bus4.busy, bus4.done_transmit, bus4.serial_data_out}, 3'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[8];
        int    bad;
        logic [7:0] w;

        vecs[0] = '{word: 8'hD7, exp_bits: 8'b1101_0111, exp_par: 1'b0, scramble: 1'b0};
        vecs[1] = '{word: 8'h29, exp_bits: 8'b0010_1001, exp_par: 1'b1, scramble: 1'b1};
        vecs[2] = '{word: 8'hA6, exp_bits: 8'b1010_0110, exp_par: 1'b0, scramble: 1'b0};
        vecs[3] = '{word: 8'hD6, exp_bits: 8'b1101_0110, exp_par: 1'b1, scramble: 1'b1};
        vecs[4] = '{word: 8'h01, exp_bits: 8'b0000_0001, exp_par: 1'b1, scramble: 1'b1};
        vecs[5] = '{word: 8'hFF, exp_bits: 8'b1111_1111, exp_par: 1'b0, scramble: 1'b1};
        vecs[6] = '{word: 8'h80, exp_bits: 8'b1000_0000, exp_par: 1'b1, scramble: 1'b1};
        vecs[7] = '{word: 8'h00, exp_bits: 8'b0000_0000, exp_par: 1'b0, scramble: 1'b1};

        reset        = 1'b1;
        bus4.start   = 1'b0;
        bus4.data_in = '0;
        bus1.start   = 1'b0;
        bus1.data_in = '0;

        repeat (2) @(negedge clk);
        check("reset div4", {bus4.busy, bus4.done_transmit, bus4.serial_data_out}, 3'b000);
        check("reset div1", {bus1.busy, bus1.done_transmit, bus1.serial_data_out}, 3'b000);
        reset = 1'b0;

        // Table: re-arm with start low for one cycle, then send and compare per cycle.
        foreach (vecs[i]) begin
            bus4.start = 1'b0;
            @(negedge clk);
            check($sformatf("rearm%0d", i),
                  {bus4.busy, bus4.done_transmit, bus4.serial_data_out}, 3'b000);
            bus4.start   = 1'b1;
            bus4.data_in = vecs[i].word;
            check_stream(expand(vecs[i].exp_bits, vecs[i].exp_par, 4),
                         $sformatf("vec%0d", i), vecs[i].scramble);
        end

        // Sticky done: start held high must not retransmit.
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if ({bus4.busy, bus4.done_transmit, bus4.serial_data_out} !== 3'b010) bad++;
            bus4.data_in = 8'($urandom);
        end
        check("sticky done", bad, 0);
        bus4.start = 1'b0;
        @(negedge clk);
        check("sticky rearm", bus4.done_transmit, 1'b0);
        bus4.start   = 1'b1;
        bus4.data_in = 8'h29;
        check_stream(expand(8'b0010_1001, 1'b1, 4), "resend29", 1'b0);

        // Abort: asynchronous reset three bits into 8'hA6.
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start   = 1'b1;
        bus4.data_in = 8'hA6;
        @(posedge clk);
        @(negedge clk);
        repeat (12) @(negedge clk);
        check("abort pre busy", {bus4.busy, bus4.done_transmit}, 2'b10);
        #2 reset = 1'b1;
        #1 check("abort immediate", {bus4.busy, bus4.done_transmit, bus4.serial_data_out}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort held", {bus4.busy, bus4.done_transmit, bus4.serial_data_out}, 3'b000);
        reset = 1'b0;
        check_stream(model_stream(8'hA6, 4), "abort resend", 1'b0);

        // Randomized words against the reference model, data_in churning during shift.
        for (int r = 0; r < 20; r++) begin
            bus4.start = 1'b0;
            @(negedge clk);
            w            = 8'($urandom);
            bus4.start   = 1'b1;
            bus4.data_in = w;
            check_stream(model_stream(w, 4), $sformatf("rand%0d_%02h", r, w), 1'b1);
        end

        // CLK_DIV=1: 8'h01 gives seven low cycles then one high, done on the 9th edge.
        @(negedge clk);
        bus1.start   = 1'b1;
        bus1.data_in = 8'h01;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("div1 bit%0d", k),
                  {bus1.busy, bus1.done_transmit, bus1.serial_data_out},
                  {1'b1, 1'b0, (k == 7)});
            bus1.data_in = 8'($urandom);
            @(negedge clk);
        end
        if (PAR == 1) begin
            check("div1 parity", {bus1.busy, bus1.done_transmit, bus1.serial_data_out}, 3'b101);
            @(negedge clk);
        end
        check("div1 done", {bus1.busy, bus1.done_transmit, bus1.serial_data_out}, 3'b010);
        bus1.start = 1'b0;
        @(negedge clk);
        check("div1 rearm", bus1.done_transmit, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
